fmul_share_arbiter: RTL and testbench
=====================================

Name: fmul_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one float64_mul core among NUM_REQ independent requesters.
- Accepts one multiply request at a time and drives the core's ap_start/ap_ready/ap_done handshake.
- Captures the result and returns it to the granted requester over a valid/ready response channel.
- Sits between the test/compute loops and the single float64_mul instance, replacing direct per-loop core ownership.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
REQ_IDX_W, 2, width of requester index, equal to clog2(NUM_REQ)
DW, 64, operand/result width (IEEE-754 double bit pattern)

Ports:
ap_clk  in  1  clock, all logic on rising edge
ap_rst_n  in  1  synchronous reset, active-low
req_valid  in  NUM_REQ  per-requester request valid
req_a  in  NUM_REQ*DW  operand a; requester k occupies bits [k*DW +: DW]
req_b  in  NUM_REQ*DW  operand b; same packing as req_a
req_ready  out  NUM_REQ  one-hot accept pulse
resp_valid  out  NUM_REQ  one-hot result valid
resp_ready  in  NUM_REQ  per-requester result accept
resp_data  out  DW  result, shared by all requesters; qualified by resp_valid
core_ap_start  out  1  to float64_mul ap_start
core_ap_ready  in  1  from float64_mul ap_ready
core_ap_done  in  1  from float64_mul ap_done
core_a  out  DW  to float64_mul a; held stable from ISSUE through WAIT
core_b  out  DW  to float64_mul b; held stable from ISSUE through WAIT
core_ap_return  in  DW  from float64_mul ap_return; valid when core_ap_done=1
busy  out  1  high in any state other than IDLE
grant_id  out  REQ_IDX_W  index of the current owner; 0 in IDLE after reset
op_count  out  32  completed operations; wraps modulo 2^32

Behaviour:
- Reset (ap_rst_n=0 at a clock edge) forces:
  - state=IDLE and rr_ptr=0
  - req_ready=0, resp_valid=0, core_ap_start=0, busy=0, grant_id=0
  - op_count=0, core_a=0, core_b=0, resp_data=0
- Reset mid-operation abandons the transaction and emits no response. The integrator drives the core reset from the same signal (inverted to the core's active-high ap_rst), so the core restarts cleanly.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, select the first set bit scanning from rr_ptr upward, wrapping from NUM_REQ-1 to 0.
  - Pulse req_ready[sel]=1 combinationally in this cycle only; the handshake completes in this cycle.
  - Register grant_id=sel, core_a=req_a[sel], core_b=req_b[sel]; next state ISSUE.
  - With no request, stay in IDLE; all outputs are 0 except the registered values.
- ISSUE:
  - core_ap_start=1 (registered, asserted the cycle after acceptance) and held until core_ap_ready=1.
  - On the core_ap_ready cycle, drop start next cycle.
  - If core_ap_done=1 in the same cycle, capture the result and go to RESP; otherwise go to WAIT.
- WAIT:
  - core_ap_start=0.
  - On core_ap_done=1, register resp_data=core_ap_return; next state RESP.
  - There is no timeout.
- RESP:
  - resp_valid[grant_id]=1, all other bits 0; resp_data is stable.
  - On resp_ready[grant_id]=1: op_count+=1, rr_ptr=(grant_id+1) mod NUM_REQ, next state IDLE.
  - resp_ready bits of non-owners are ignored.
- Minimum latency from acceptance to resp_valid is core latency + 2 cycles. Back-to-back throughput is one op per (core latency + 3) cycles.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.
- A requester may deassert req_valid before acceptance; it is not granted.
- Operands are sampled only in the accept cycle; later changes to req_a/req_b are ignored.
- rr_ptr advances only on response completion, never on a request that is not accepted.
- No arithmetic in the block except op_count, which is 32-bit unsigned with natural wrap.
- Stray core_ap_done in IDLE or RESP is ignored.

Test Plan:
- Single op: after reset, req_valid=0001, a0=0x4000000000000000, b0=0x4008000000000000 -> req_ready=0001 for 1 cycle, core_ap_start next cycle, resp_valid=0001 with resp_data=0x4018000000000000, op_count=1.
- Round-robin: req_valid=1111 held, each requester's resp_ready tied high -> grant order 0,1,2,3,0; each resp_data matches its own operand product.
- Response backpressure: resp_ready[2]=0 for 10 cycles -> resp_valid=0100 and resp_data held 10 cycles, no new req_ready, busy=1; completes on the cycle resp_ready[2] rises.
- Skip idle requesters: after a grant to 1, req_valid=1001 -> next grant 3, then 0.
- Reset mid-op: ap_rst_n=0 during WAIT -> next cycle state IDLE, busy=0, resp_valid=0, core_ap_start=0, op_count=0, rr_ptr=0; a subsequent request to 0 completes normally.
- op_count wrap: preload via 2^32 ops (or force the counter to 0xFFFFFFFF) -> one more completion gives op_count=0.

Source files
------------

// File: rtl/fmul_share_arbiter_if.sv
// Handshake bundle between the requesters, the shared arbiter and the float64_mul core.
interface fmul_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 64
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_a;
  logic [NUM_REQ*DW-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [NUM_REQ-1:0]    resp_ready;
  logic [DW-1:0]         resp_data;
  logic                  core_ap_start;
  logic                  core_ap_ready;
  logic                  core_ap_done;
  logic [DW-1:0]         core_a;
  logic [DW-1:0]         core_b;
  logic [DW-1:0]         core_ap_return;

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    input  core_ap_ready, core_ap_done, core_ap_return,
    output req_ready, resp_valid, resp_data,
    output core_ap_start, core_a, core_b
  );

  // Requester / core side
  modport master (
    output req_valid, req_a, req_b, resp_ready,
    output core_ap_ready, core_ap_done, core_ap_return,
    input  req_ready, resp_valid, resp_data,
    input  core_ap_start, core_a, core_b
  );
endinterface

// File: rtl/fmul_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one float64_mul core among NUM_REQ requesters.
module fmul_share_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int REQ_IDX_W = 2,
  parameter int DW        = 64
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  fmul_share_arbiter_if.slave  bus,
  output logic                 busy,
  output logic [REQ_IDX_W-1:0] grant_id,
  output logic [31:0]          op_count
);

  localparam logic [REQ_IDX_W-1:0] LAST_IDX = REQ_IDX_W'(NUM_REQ - 1);
  localparam logic [REQ_IDX_W:0]   NR_EXT   = (REQ_IDX_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t               r_state;
  logic [REQ_IDX_W-1:0] r_rr_ptr;
  logic [REQ_IDX_W-1:0] r_grant;
  logic                 r_start;
  logic                 r_busy;
  logic [NUM_REQ-1:0]   r_resp_valid;
  logic [DW-1:0]        r_resp_data;
  logic [DW-1:0]        r_core_a;
  logic [DW-1:0]        r_core_b;
  logic [31:0]          r_op_count;

  logic [DW-1:0]        w_a_arr [NUM_REQ];
  logic [DW-1:0]        w_b_arr [NUM_REQ];
  logic                 w_any;
  logic [REQ_IDX_W-1:0] w_sel;
  logic [REQ_IDX_W:0]   w_sum;
  logic [REQ_IDX_W-1:0] w_cand;
  logic [NUM_REQ-1:0]   w_sel_oh;
  logic [NUM_REQ-1:0]   w_grant_oh;
  logic                 w_owner_ready;
  logic [REQ_IDX_W-1:0] w_next_ptr;

  // Unpack the flat operand buses so they can be indexed by requester number
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign w_a_arr[k] = bus.req_a[k*DW +: DW];
    assign w_b_arr[k] = bus.req_b[k*DW +: DW];
  end

  // First requesting index scanning upward from rr_ptr with wrap to 0
  always_comb begin
    w_any  = 1'b0;
    w_sel  = '0;
    w_sum  = '0;
    w_cand = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // sum is one bit wider so the wrap also works for non-power-of-two NUM_REQ
      w_sum = {1'b0, r_rr_ptr} + (REQ_IDX_W+1)'(i);
      if (w_sum >= NR_EXT) w_sum = w_sum - NR_EXT;
      w_cand = w_sum[REQ_IDX_W-1:0];
      if (!w_any && bus.req_valid[w_cand]) begin
        w_any = 1'b1;
        w_sel = w_cand;
      end
    end
  end

  // One-hot decodes of the selected candidate and of the current owner
  always_comb begin
    w_sel_oh          = '0;
    w_sel_oh[w_sel]   = w_any;
    w_grant_oh        = '0;
    w_grant_oh[r_grant] = 1'b1;
  end

  assign w_owner_ready = bus.resp_ready[r_grant];
  assign w_next_ptr    = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;

  // Accept pulse is combinational so the handshake completes in the IDLE cycle
  assign bus.req_ready     = (ap_rst_n && (r_state == S_IDLE)) ? w_sel_oh : '0;
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_data     = r_resp_data;
  assign bus.core_ap_start = r_start;
  assign bus.core_a        = r_core_a;
  assign bus.core_b        = r_core_b;
  assign busy              = r_busy;
  assign grant_id          = r_grant;
  assign op_count          = r_op_count;

  // Sequencer: accept, drive core handshake, capture result, return it to the owner
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_grant      <= '0;
      r_start      <= 1'b0;
      r_busy       <= 1'b0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_core_a     <= '0;
      r_core_b     <= '0;
      r_op_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant  <= w_sel;
            r_core_a <= w_a_arr[w_sel];
            r_core_b <= w_b_arr[w_sel];
            r_start  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.core_ap_ready) begin
            r_start <= 1'b0;
            if (bus.core_ap_done) begin
              r_resp_data  <= bus.core_ap_return;
              r_resp_valid <= w_grant_oh;
              r_state      <= S_RESP;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.core_ap_done) begin
            r_resp_data  <= bus.core_ap_return;
            r_resp_valid <= w_grant_oh;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_owner_ready) begin
            r_resp_valid <= '0;
            r_op_count   <= r_op_count + 32'd1;
            r_rr_ptr     <= w_next_ptr;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmul_share_arbiter.sv
// Scoreboard bench for fmul_share_arbiter with a behavioural float64_mul core model.
module tb_fmul_share_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int REQ_IDX_W = 2;
  localparam int DW        = 64;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        busy;
  logic [1:0]  grant_id;
  logic [31:0] op_count;

  fmul_share_arbiter_if #(.NUM_REQ(NUM_REQ), .DW(DW)) bus ();

  fmul_share_arbiter #(.NUM_REQ(NUM_REQ), .REQ_IDX_W(REQ_IDX_W), .DW(DW)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id),
    .op_count (op_count)
  );

  always #5 ap_clk = ~ap_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  function automatic int model_sel(input logic [3:0] v, input int p);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // ---------------- core model ----------------
  int          core_lat = 3;
  int          rdy_wait = 0;
  logic        stray = 1'b0;
  logic        c_busy = 1'b0;
  int          c_cnt = 0;
  int          s_cnt = 0;
  logic [63:0] c_res = '0;
  logic        w_rdy;

  assign w_rdy              = bus.core_ap_start && !c_busy && (s_cnt >= rdy_wait);
  assign bus.core_ap_ready  = w_rdy;
  assign bus.core_ap_done   = stray || ((core_lat == 0) ? w_rdy : (c_busy && c_cnt == 0));
  assign bus.core_ap_return = (core_lat == 0) ? fmul(bus.core_a, bus.core_b) : c_res;

  always @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      c_busy <= 1'b0; c_cnt <= 0; s_cnt <= 0; c_res <= '0;
    end else begin
      if (bus.core_ap_start && !w_rdy) s_cnt <= s_cnt + 1; else s_cnt <= 0;
      if (w_rdy && core_lat != 0) begin
        c_busy <= 1'b1; c_cnt <= core_lat - 1; c_res <= fmul(bus.core_a, bus.core_b);
      end else if (c_busy) begin
        if (c_cnt == 0) c_busy <= 1'b0; else c_cnt <= c_cnt - 1;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  typedef struct { int id; logic [63:0] res; } exp_t;
  exp_t        sb[$];
  int          grants[$];
  int          acc_q[$];
  int          rr_m = 0;
  logic [31:0] exp_ops = '0;
  int          done_cnt = 0;
  int          cyc = 0;

  always @(negedge ap_clk) begin
    int         s;
    exp_t       e;
    logic [3:0] ex_oh;
    cyc++;
    if (!ap_rst_n) begin
      sb.delete();
      rr_m = 0;
      exp_ops = '0;
    end else begin
      if (bus.req_ready != 0) begin
        s = model_sel(bus.req_valid, rr_m);
        ex_oh = (s < 0) ? 4'b0000 : onehot(s);
        check("accept_sel", bus.req_ready, ex_oh);
        if (s >= 0) begin
          e.id  = s;
          e.res = fmul(bus.req_a[s*64 +: 64], bus.req_b[s*64 +: 64]);
          sb.push_back(e);
          grants.push_back(s);
          acc_q.push_back(cyc);
        end
      end
      if ((bus.resp_valid & bus.resp_ready) != 0) begin
        if (sb.size() == 0) begin
          check("resp_unexpected", bus.resp_valid, 4'b0000);
        end else begin
          e = sb.pop_front();
          check("resp_valid", bus.resp_valid, onehot(e.id));
          check("resp_data", bus.resp_data, e.res);
          check("op_count_pre", op_count, exp_ops);
          exp_ops = exp_ops + 32'd1;
          rr_m = (e.id + 1) % NUM_REQ;
          done_cnt++;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    tick();
    tick();
    ap_rst_n = 1'b1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((busy || sb.size() != 0) && k < 300) begin tick(); k++; end
    check("drain_timeout", (k < 300), 1'b1);
  endtask

  task automatic wait_grants(input int n);
    int k;
    k = 0;
    while (grants.size() < n && k < 300) begin tick(); k++; end
    check("grant_timeout", (grants.size() >= n), 1'b1);
  endtask

  task automatic wait_resp();
    int k;
    k = 0;
    while (bus.resp_valid == 0 && k < 300) begin tick(); k++; end
    check("resp_timeout", (bus.resp_valid != 0), 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int          n;
    int          exp_g[$];
    logic [63:0] held;

    bus.req_valid  = 4'b0001;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = '0;
    ap_rst_n       = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;

    // reset state, with a request pending that must not be accepted
    check("rst_req_ready", bus.req_ready, 4'b0000);
    check("rst_resp_valid", bus.resp_valid, 4'b0000);
    check("rst_start", bus.core_ap_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant_id, 2'd0);
    check("rst_op_count", op_count, 32'd0);
    check("rst_core_a", bus.core_a, 64'd0);
    check("rst_core_b", bus.core_b, 64'd0);
    check("rst_resp_data", bus.resp_data, 64'd0);

    // single op: 2.0 * 3.0
    core_lat = 3;
    bus.req_a[0 +: 64] = 64'h4000000000000000;
    bus.req_b[0 +: 64] = 64'h4008000000000000;
    bus.resp_ready = 4'b1111;
    ap_rst_n = 1'b1;
    #1;
    check("t1_req_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = 4'b0000;
    #1;
    check("t1_req_ready_drop", bus.req_ready, 4'b0000);
    check("t1_start", bus.core_ap_start, 1'b1);
    check("t1_busy", busy, 1'b1);
    check("t1_grant", grant_id, 2'd0);
    check("t1_core_a", bus.core_a, 64'h4000000000000000);
    check("t1_core_b", bus.core_b, 64'h4008000000000000);
    tick();
    check("t1_start_drop", bus.core_ap_start, 1'b0);
    n = 2;
    while (bus.resp_valid == 0 && n < 50) begin tick(); n++; end
    check("t1_latency", n, core_lat + 2);
    check("t1_resp_valid", bus.resp_valid, 4'b0001);
    check("t1_resp_data", bus.resp_data, 64'h4018000000000000);
    tick();
    check("t1_op_count", op_count, 32'd1);
    check("t1_idle", busy, 1'b0);

    // round robin with all requesters held
    do_reset();
    grants.delete();
    acc_q.delete();
    core_lat = 2;
    for (int k = 0; k < NUM_REQ; k++) begin
      bus.req_a[k*64 +: 64] = $realtobits(1.5 + k);
      bus.req_b[k*64 +: 64] = $realtobits(-2.0 - 0.25 * k);
    end
    bus.req_valid = 4'b1111;
    wait_grants(5);
    bus.req_valid = 4'b0000;
    drain();
    exp_g = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++)
      check("t2_grant_order", (grants.size() > k) ? grants[k] : -1, exp_g[k]);
    check("t2_throughput", (acc_q.size() > 2) ? (acc_q[2] - acc_q[1]) : -1, core_lat + 3);

    // response backpressure on requester 2; non-owner resp_ready bits must be ignored
    do_reset();
    bus.resp_ready = 4'b1011;
    bus.req_valid  = 4'b0100;
    wait_resp();
    bus.req_valid = 4'b1011;
    held = fmul(bus.req_a[2*64 +: 64], bus.req_b[2*64 +: 64]);
    for (int k = 0; k < 10; k++) begin
      check("t3_resp_valid", bus.resp_valid, 4'b0100);
      check("t3_resp_data", bus.resp_data, held);
      check("t3_no_accept", bus.req_ready, 4'b0000);
      check("t3_busy", busy, 1'b1);
      tick();
    end
    bus.resp_ready = 4'b1111;
    tick();
    check("t3_released", bus.resp_valid, 4'b0000);
    check("t3_next_grant", bus.req_ready, 4'b1000);
    check("t3_op_count", op_count, 32'd1);
    tick();
    bus.req_valid = 4'b0000;
    drain();

    // skip idle requesters: grant 1, then only 3 and 0 request
    do_reset();
    grants.delete();
    bus.req_valid = 4'b0010;
    wait_grants(1);
    bus.req_valid = 4'b1001;
    wait_grants(3);
    bus.req_valid = 4'b0000;
    drain();
    exp_g = '{1, 3, 0};
    for (int k = 0; k < 3; k++)
      check("t4_grant_order", (grants.size() > k) ? grants[k] : -1, exp_g[k]);

    // zero-latency core (done with ready), delayed ready, operands changed after accept
    core_lat = 0;
    rdy_wait = 2;
    bus.req_a[0 +: 64] = $realtobits(2.5);
    bus.req_b[0 +: 64] = $realtobits(4.0);
    bus.req_valid = 4'b0001;
    #1;
    check("t5_req_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = 4'b0000;
    bus.req_a[0 +: 64] = $realtobits(7.0);
    bus.req_b[0 +: 64] = $realtobits(9.0);
    n = 0;
    while (bus.core_ap_start && n < 20) begin n++; tick(); end
    check("t5_start_hold", n, rdy_wait + 1);
    check("t5_same_cycle_done", bus.resp_valid, 4'b0001);
    check("t5_core_a_stable", bus.core_a, $realtobits(2.5));
    drain();
    rdy_wait = 0;
    core_lat = 3;

    // stray done while idle
    stray = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_stray_busy", busy, 1'b0);
      check("t6_stray_resp", bus.resp_valid, 4'b0000);
    end
    stray = 1'b0;

    // reset in the middle of an operation
    core_lat = 8;
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = 4'b0000;
    repeat (3) tick();
    check("t7_in_wait_start", bus.core_ap_start, 1'b0);
    check("t7_in_wait_busy", busy, 1'b1);
    ap_rst_n = 1'b0;
    tick();
    check("t7_busy", busy, 1'b0);
    check("t7_resp_valid", bus.resp_valid, 4'b0000);
    check("t7_start", bus.core_ap_start, 1'b0);
    check("t7_op_count", op_count, 32'd0);
    check("t7_grant", grant_id, 2'd0);
    ap_rst_n = 1'b1;
    core_lat = 3;
    bus.req_valid = 4'b1001;
    #1;
    check("t7_rr_reset", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = 4'b0000;
    drain();
    check("t7_after_op", op_count, 32'd1);

    // op_count wrap
    force dut.r_op_count = 32'hFFFF_FFFF;
    tick();
    release dut.r_op_count;
    tick();
    check("t8_preload", op_count, 32'hFFFF_FFFF);
    exp_ops = 32'hFFFF_FFFF;
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'b0000;
    drain();
    check("t8_wrap", op_count, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
